// File: rtl/video_timing_if.sv
// Raster timing bundle driven by video_timing and consumed by the layer pipeline.
//   hsync/vsync        sync outputs at the configured polarity
//   hPos/vPos          current raster position
//   nextVPos           line following vPos (wraps to 0)
//   displayActive      inside the visible window
//   hsyncStarting      first hsync cycle of every line
//   nextFrameActive    nextVPos is a visible line
//   lineStarting       pulse LEAD clocks before pixel 0 of a visible line
//   lineEnding         pulse LEAD clocks before column H_ACTIVE of a visible line
//   frameStarting      pulse at (0,0)
interface video_timing_if;
  logic       hsync;
  logic       vsync;
  logic [9:0] hPos;
  logic [9:0] vPos;
  logic [9:0] nextVPos;
  logic       displayActive;
  logic       hsyncStarting;
  logic       nextFrameActive;
  logic       lineStarting;
  logic       lineEnding;
  logic       frameStarting;

  modport master (
    output hsync, vsync, hPos, vPos, nextVPos, displayActive, hsyncStarting,
           nextFrameActive, lineStarting, lineEnding, frameStarting
  );

  modport slave (
    input  hsync, vsync, hPos, vPos, nextVPos, displayActive, hsyncStarting,
           nextFrameActive, lineStarting, lineEnding, frameStarting
  );
endinterface

// File: rtl/video_timing.sv
// Raster timing generator for the pixel-clock domain.
//   clkPixel  pixel clock, rising edge
//   resetN    asynchronous active-low reset
//   vt        timing outputs (video_timing_if master), all flop outputs
// Every output is decoded from the next counter values so that it is aligned
// with the hPos/vPos it describes on the same cycle.
module video_timing #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned LEAD     = 2
) (
  input  logic           clkPixel,
  input  logic           resetN,
  video_timing_if.master vt
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [CW-1:0] LS_COL   = CW'(H_TOTAL - LEAD);
  localparam logic [CW-1:0] LE_COL   = CW'(H_ACTIVE - LEAD);

  // Refuse to elaborate a configuration that the 10-bit counters or the lead cannot express.
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || LEAD < 1 || LEAD > H_BACK) begin : g_bad_params
    $error("video_timing: illegal parameter combination");
  end

  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] v_q, v_d;
  logic [CW-1:0] nv_q, nv_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic de_q, de_d;
  logic hss_q, hss_d;
  logic nfa_q, nfa_d;
  logic ls_q, ls_d;
  logic le_q, le_d;
  logic fs_q, fs_d;

  // Next counter values and the decode of every output from them.
  always_comb begin
    h_d     = (h_q == H_LAST) ? '0 : h_q + CW'(1);
    v_d     = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
    end
    nv_d    = (v_d == V_LAST) ? '0 : v_d + CW'(1);

    hsync_d = (h_d >= HS_FIRST && h_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_d >= VS_FIRST && v_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
    de_d    = (h_d < H_VIS) && (v_d < V_VIS);
    hss_d   = (h_d == HS_FIRST);
    nfa_d   = (nv_d < V_VIS);
    // Line 0's start strobe lands on the last line of the previous frame.
    ls_d    = (h_d == LS_COL) && (nv_d < V_VIS);
    le_d    = (h_d == LE_COL) && (v_d < V_VIS);
    fs_d    = (h_d == '0) && (v_d == '0);
  end

  // Counter and output registers.
  always_ff @(posedge clkPixel or negedge resetN) begin
    if (!resetN) begin
      h_q     <= '0;
      v_q     <= '0;
      nv_q    <= CW'(1);
      hsync_q <= ~SYNC_POL;
      vsync_q <= ~SYNC_POL;
      de_q    <= 1'b0;
      hss_q   <= 1'b0;
      nfa_q   <= 1'b0;
      ls_q    <= 1'b0;
      le_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      nv_q    <= nv_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      hss_q   <= hss_d;
      nfa_q   <= nfa_d;
      ls_q    <= ls_d;
      le_q    <= le_d;
      fs_q    <= fs_d;
    end
  end

  assign vt.hPos            = h_q;
  assign vt.vPos            = v_q;
  assign vt.nextVPos        = nv_q;
  assign vt.hsync           = hsync_q;
  assign vt.vsync           = vsync_q;
  assign vt.displayActive   = de_q;
  assign vt.hsyncStarting   = hss_q;
  assign vt.nextFrameActive = nfa_q;
  assign vt.lineStarting    = ls_q;
  assign vt.lineEnding      = le_q;
  assign vt.frameStarting   = fs_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a small raster (32x19, active-high sync) for frame-level
// behaviour, plus a default-parameter instance checked over its first line.
module tb_video_timing;

  localparam int HT_S = 32;
  localparam int FR_S = 32 * 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_timing_if vt_s ();
  video_timing_if vt_d ();

  video_timing #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(6),
    .V_ACTIVE(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(1'b1), .LEAD(2)
  ) u_small (
    .clkPixel(clk), .resetN(rst_n), .vt(vt_s)
  );

  video_timing u_dflt (
    .clkPixel(clk), .resetN(rst_n), .vt(vt_d)
  );

  typedef struct {
    int   inst;
    int   frame;
    int   h;
    int   v;
    logic hs, vs, de, hss, nfa, ls, le, fs;
    int   nv;
  } vec_t;

  vec_t tbl[33];
  int n_checks = 0;
  int n_pass   = 0;
  int cur      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_vec(input int i, input vec_t e);
    int h, v, nv, hs, vs, de, hss, nfa, ls, le, fs;
    if (e.inst == 0) begin
      h = int'(vt_s.hPos); v = int'(vt_s.vPos); nv = int'(vt_s.nextVPos);
      hs = int'(vt_s.hsync); vs = int'(vt_s.vsync); de = int'(vt_s.displayActive);
      hss = int'(vt_s.hsyncStarting); nfa = int'(vt_s.nextFrameActive);
      ls = int'(vt_s.lineStarting); le = int'(vt_s.lineEnding); fs = int'(vt_s.frameStarting);
    end else begin
      h = int'(vt_d.hPos); v = int'(vt_d.vPos); nv = int'(vt_d.nextVPos);
      hs = int'(vt_d.hsync); vs = int'(vt_d.vsync); de = int'(vt_d.displayActive);
      hss = int'(vt_d.hsyncStarting); nfa = int'(vt_d.nextFrameActive);
      ls = int'(vt_d.lineStarting); le = int'(vt_d.lineEnding); fs = int'(vt_d.frameStarting);
    end
    chk($sformatf("v%0d.hPos", i), h, e.h);
    chk($sformatf("v%0d.vPos", i), v, e.v);
    chk($sformatf("v%0d.nextVPos", i), nv, e.nv);
    chk($sformatf("v%0d.hsync", i), hs, int'(e.hs));
    chk($sformatf("v%0d.vsync", i), vs, int'(e.vs));
    chk($sformatf("v%0d.displayActive", i), de, int'(e.de));
    chk($sformatf("v%0d.hsyncStarting", i), hss, int'(e.hss));
    chk($sformatf("v%0d.nextFrameActive", i), nfa, int'(e.nfa));
    chk($sformatf("v%0d.lineStarting", i), ls, int'(e.ls));
    chk($sformatf("v%0d.lineEnding", i), le, int'(e.le));
    chk($sformatf("v%0d.frameStarting", i), fs, int'(e.fs));
  endtask

  initial begin
    int tgt, n_ls, n_le, n_hss, n_fs, n_vs, n_hs, wide, alt, last, early;
    logic p_ls, p_le, p_hss, p_fs;

    //          inst frm  h   v   hs vs de hss nfa ls le fs nv
    tbl[0]  = '{0, 0,  1,  0, 0, 0, 1, 0, 1, 0, 0, 0, 1};
    tbl[1]  = '{0, 0, 14,  0, 0, 0, 1, 0, 1, 0, 1, 0, 1};
    tbl[2]  = '{0, 0, 15,  0, 0, 0, 1, 0, 1, 0, 0, 0, 1};
    tbl[3]  = '{0, 0, 16,  0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[4]  = '{0, 0, 19,  0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[5]  = '{0, 0, 20,  0, 1, 0, 0, 1, 1, 0, 0, 0, 1};
    tbl[6]  = '{0, 0, 25,  0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[7]  = '{0, 0, 26,  0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[8]  = '{0, 0, 30,  0, 0, 0, 0, 0, 1, 1, 0, 0, 1};
    tbl[9]  = '{0, 0, 31,  0, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    tbl[10] = '{0, 0,  0,  1, 0, 0, 1, 0, 1, 0, 0, 0, 2};
    tbl[11] = '{0, 0, 20, 10, 1, 0, 0, 1, 1, 0, 0, 0, 11};
    tbl[12] = '{0, 0, 30, 10, 0, 0, 0, 0, 1, 1, 0, 0, 11};
    tbl[13] = '{0, 0, 14, 11, 0, 0, 1, 0, 0, 0, 1, 0, 12};
    tbl[14] = '{0, 0, 20, 11, 1, 0, 0, 1, 0, 0, 0, 0, 12};
    tbl[15] = '{0, 0, 30, 11, 0, 0, 0, 0, 0, 0, 0, 0, 12};
    tbl[16] = '{0, 0,  0, 12, 0, 0, 0, 0, 0, 0, 0, 0, 13};
    tbl[17] = '{0, 0, 14, 12, 0, 0, 0, 0, 0, 0, 0, 0, 13};
    tbl[18] = '{0, 0, 31, 13, 0, 0, 0, 0, 0, 0, 0, 0, 14};
    tbl[19] = '{0, 0,  0, 14, 0, 1, 0, 0, 0, 0, 0, 0, 15};
    tbl[20] = '{0, 0, 31, 15, 0, 1, 0, 0, 0, 0, 0, 0, 16};
    tbl[21] = '{0, 0,  0, 16, 0, 0, 0, 0, 0, 0, 0, 0, 17};
    tbl[22] = '{0, 0, 20, 17, 1, 0, 0, 1, 0, 0, 0, 0, 18};
    tbl[23] = '{0, 0, 20, 18, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[24] = '{0, 0, 30, 18, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    tbl[25] = '{0, 1,  0,  0, 0, 0, 1, 0, 1, 0, 0, 1, 1};
    tbl[26] = '{0, 1,  1,  0, 0, 0, 1, 0, 1, 0, 0, 0, 1};
    tbl[27] = '{1, 0, 638, 0, 1, 1, 1, 0, 1, 0, 1, 0, 1};
    tbl[28] = '{1, 0, 655, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1};
    tbl[29] = '{1, 0, 656, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1};
    tbl[30] = '{1, 0, 751, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1};
    tbl[31] = '{1, 0, 752, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1};
    tbl[32] = '{1, 0, 798, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1};

    // Reset state, both instances.
    repeat (3) @(negedge clk);
    chk("rst.hPos", int'(vt_s.hPos), 0);
    chk("rst.vPos", int'(vt_s.vPos), 0);
    chk("rst.nextVPos", int'(vt_s.nextVPos), 1);
    chk("rst.hsync_s", int'(vt_s.hsync), 0);
    chk("rst.vsync_s", int'(vt_s.vsync), 0);
    chk("rst.hsync_d", int'(vt_d.hsync), 1);
    chk("rst.vsync_d", int'(vt_d.vsync), 1);
    chk("rst.pulses", int'({vt_s.displayActive, vt_s.hsyncStarting, vt_s.nextFrameActive,
                            vt_s.lineStarting, vt_s.lineEnding, vt_s.frameStarting}), 0);

    rst_n = 1'b1;
    cur = 0;

    // Table-driven vectors; cycle index counts from the reset release.
    for (int i = 0; i < 33; i++) begin
      tgt = (tbl[i].inst == 0) ? (tbl[i].frame * FR_S + tbl[i].v * HT_S + tbl[i].h) : tbl[i].h;
      repeat (tgt - cur) @(negedge clk);
      cur = tgt;
      check_vec(i, tbl[i]);
    end

    // Two whole frames of the small raster: pulse counts, widths and pairing.
    repeat (2 * FR_S - cur) @(negedge clk);
    n_ls = 0; n_le = 0; n_hss = 0; n_fs = 0; n_vs = 0; n_hs = 0;
    wide = 0; alt = 0; last = 0;
    p_ls = 1'b0; p_le = 1'b0; p_hss = 1'b0; p_fs = 1'b0;
    for (int k = 0; k < 2 * FR_S; k++) begin
      if (k != 0) @(negedge clk);
      if (vt_s.lineStarting) begin n_ls++; if (last == 1) alt++; last = 1; end
      if (vt_s.lineEnding)   begin n_le++; if (last == 2) alt++; last = 2; end
      if (vt_s.hsyncStarting) n_hss++;
      if (vt_s.frameStarting) n_fs++;
      if (vt_s.vsync) n_vs++;
      if (vt_s.hsync) n_hs++;
      if ((vt_s.lineStarting && p_ls) || (vt_s.lineEnding && p_le) ||
          (vt_s.hsyncStarting && p_hss) || (vt_s.frameStarting && p_fs)) wide++;
      p_ls = vt_s.lineStarting; p_le = vt_s.lineEnding;
      p_hss = vt_s.hsyncStarting; p_fs = vt_s.frameStarting;
    end
    cur = 4 * FR_S - 1;
    chk("frm.lineStarting_count", n_ls, 24);
    chk("frm.lineEnding_count", n_le, 24);
    chk("frm.hsyncStarting_count", n_hss, 38);
    chk("frm.frameStarting_count", n_fs, 2);
    chk("frm.vsync_cycles", n_vs, 128);
    chk("frm.hsync_cycles", n_hs, 228);
    chk("frm.pulse_width_violations", wide, 0);
    chk("frm.pairing_violations", alt, 0);

    // Mid-frame reset one clock before a lineEnding; it must not appear.
    tgt = 4 * FR_S + 5 * HT_S + 13;
    repeat (tgt - cur) @(negedge clk);
    chk("mid.hPos_before", int'(vt_s.hPos), 13);
    chk("mid.vPos_before", int'(vt_s.vPos), 5);
    rst_n = 1'b0;
    #1;
    chk("mid.hPos", int'(vt_s.hPos), 0);
    chk("mid.vPos", int'(vt_s.vPos), 0);
    chk("mid.nextVPos", int'(vt_s.nextVPos), 1);
    chk("mid.displayActive", int'(vt_s.displayActive), 0);
    chk("mid.hsync_d", int'(vt_d.hsync), 1);
    repeat (2) @(negedge clk);
    chk("mid.lineEnding_held", int'(vt_s.lineEnding), 0);
    rst_n = 1'b1;
    early = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) chk("mid.hPos_first_edge", int'(vt_s.hPos), 1);
      if (k < 14 && vt_s.lineEnding) early++;
    end
    chk("mid.early_lineEnding", early, 0);
    chk("mid.lineEnding", int'(vt_s.lineEnding), 1);
    chk("mid.lineEnding_hPos", int'(vt_s.hPos), 14);
    chk("mid.lineEnding_vPos", int'(vt_s.vPos), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
